// File: rtl/cla_pkg.sv
// Shared types and limits for the pipelined carry-lookahead adder.
// Imported by cla_pipe.
package cla_pkg;

  typedef enum logic {
    CLA_ADD = 1'b0,
    CLA_SUB = 1'b1
  } cla_op_e;

  localparam int BLK_MIN = 2;
  localparam int BLK_MAX = 16;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cla_blk.sv
// One BLOCK-bit carry-lookahead slice.
// Purely combinational; cla_pipe registers its outputs.
module cla_blk #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] x;
  logic [BLOCK:0]   c;
  logic             t;
  logic             pp;

  assign g = a & b;
  assign p = a | b;
  assign x = a ^ b;

  // each carry is a flat sum-of-products over g/p, not a ripple chain
  always_comb begin
    c    = '0;
    t    = 1'b0;
    pp   = 1'b1;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      t  = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & cin);
    end
  end

  assign sum  = x ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead add/sub, one BLOCK per stage.
// Valid/ready with a single global advance enable.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NUM_BLK = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_chk_w
    $error("cla_pipe: WIDTH must be a multiple of BLOCK");
  end

  if (BLOCK < BLK_MIN || BLOCK > BLK_MAX ||
      !is_pow2(BLOCK)) begin : g_chk_b
    $error("cla_pipe: BLOCK must be a power of two in 2..16");
  end

  typedef struct packed {
    logic             vld;
    cla_op_e          op;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             cm;
  } stg_t;

  stg_t head;
  stg_t last;
  logic adv;

  assign adv      = !last.vld | out_ready;
  assign in_ready = adv;

  // subtract folds into add: A + ~B + ~borrow
  always_comb begin
    head     = '0;
    head.vld = in_valid;
    head.op  = in_op ? CLA_SUB : CLA_ADD;
    head.tag = in_tag;
    head.a   = in_a;
    head.b   = in_op ? ~in_b : in_b;
    head.c   = in_op ^ in_cin;
  end

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stg
    stg_t             src;
    stg_t             nxt;
    stg_t             q;
    logic [BLOCK-1:0] bsum;
    logic             bco;
    logic             bcm;

    if (k == 0) begin : g_src0
      assign src = head;
    end else begin : g_srck
      assign src = g_stg[k-1].q;
    end

    cla_blk #(.BLOCK(BLOCK)) u_blk (
      .a    (src.a[k*BLOCK +: BLOCK]),
      .b    (src.b[k*BLOCK +: BLOCK]),
      .cin  (src.c),
      .sum  (bsum),
      .cout (bco),
      .cmsb (bcm)
    );

    always_comb begin
      nxt                      = src;
      nxt.sum[k*BLOCK +: BLOCK] = bsum;
      nxt.c                    = bco;
      nxt.cm                   = bcm;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (adv) begin
        q <= nxt;
      end
    end
  end

  assign last = g_stg[NUM_BLK-1].q;

  assign out_valid = last.vld;
  assign out_sum   = last.sum;
  assign out_cout  = last.c;
  assign out_ovf   = last.cm ^ last.c;
  assign out_zero  = last.vld & ~|last.sum;
  assign out_tag   = last.tag;

  logic unused_last;
  assign unused_last = ^{last.a, last.b, last.op};

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. It generalises the 32-bit combinational CLA.
- Operands are split into NUM_BLK blocks of BLOCK bits. One block is resolved per pipeline stage, with block-level lookahead inside each stage and a registered carry between stages.
- Adds a subtract mode, flags (carry, overflow, zero), a transaction tag and a valid/ready handshake with backpressure.
- Feeds the ALU writeback path wherever single-cycle 32-bit carry propagation misses timing.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per stage; must be a power of two, 2..16.
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- NUM_BLK, WIDTH/BLOCK, derived (localparam); equals pipeline depth/latency.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  1  0 = add (A+B+cin), 1 = subtract (A-B-borrow)
- in_cin  in  1  carry-in (add) / borrow-in (subtract)
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB; for subtract 1 = no borrow
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Operand preparation at stage 0:
  - Add: B' = in_b, c0 = in_cin.
  - Subtract: B' = ~in_b, c0 = ~in_cin.
- Stage k (0..NUM_BLK-1) computes sum bits [k*BLOCK +: BLOCK] from A, B' and the carry registered by stage k-1 (c0 for k = 0).
  - Computation is per-bit g = a&b, p = a|b, with block lookahead carries.
  - Each stage registers: valid, partial sum (bits resolved so far), remaining A/B' bits, carry, op, tag, and the carry into the MSB (needed for overflow).
- Results:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry-into-MSB XOR out_cout.
  - out_zero is computed from the final registered sum.
- Latency: exactly NUM_BLK cycles from an accepted input (in_valid & in_ready) to out_valid, absent stalls. Throughput is 1 op/cycle.
- Flow control:
  - Global advance enable adv = !out_valid | out_ready; in_ready = adv (combinational, no dependence on in_valid).
  - When adv = 0, every stage register, including valids, holds.
  - Bubbles are not collapsed; an invalid stage still occupies its slot.
  - out_* fields hold stable while out_valid & !out_ready.
  - in_valid while in_ready = 0: the input is not captured; the producer must hold it.
- Reset (asynchronous, any time, including mid-operation):
  - All stage valids clear immediately.
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0, out_tag = 0.
  - In-flight operations are discarded; in_ready = 1 once reset deasserts.
- Boundary cases:
  - All-ones + 1 wraps to 0 with cout = 1.
  - Subtract of equal operands with borrow-in 0 gives sum 0, zero = 1, cout = 1.
  - NUM_BLK = 1 degenerates to a single registered stage (latency 1).
- Simultaneous accept at input and drain at output in the same cycle is legal and required for full throughput.

Decomposition:
- Package cla_pkg:
  - typedef enum logic {CLA_ADD, CLA_SUB} cla_op_e.
  - Stage-record struct parameterised via macro or per-instance typedef.
  - Elaboration assertions on WIDTH % BLOCK == 0 and the BLOCK range.
- Sub-module cla_blk #(BLOCK): combinational g/p + lookahead for one block.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and carry into the block MSB.
  - cla_pipe instantiates NUM_BLK copies in a generate loop with stage registers between them.

Test Plan:
- WIDTH=32, BLOCK=8, add 0xFFFFFFFF + 0x00000001, cin=0 -> after 4 cycles: sum=0x00000000, cout=1, zero=1, ovf=0.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, cout=0. Then subtract 5 - 7, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0.
- Stream 8 back-to-back ops with tags 0..7 and out_ready=1 -> in_ready stays 1; results emerge in order, one per cycle starting at cycle 4; tags match.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_* stable, no op lost or duplicated. Release -> in-order drain.
- Assert rst for 1 cycle while 3 ops are in flight -> out_valid drops immediately with outputs zeroed. A new op after reset returns its correct result 4 cycles later, with no stale results.
- WIDTH=16, BLOCK=4: 10,000 random add/sub ops with random stalls, checked against a reference model (sum, cout, ovf, zero, tag). Latency is 4 when unstalled.
